// File: rtl/fft_frame_collector.sv
`default_nettype none
// ============================================================================
// fft_frame_collector : serial sample stream -> ping-pong frames, bit-reversed
// Revision 1.0
// ============================================================================
module fft_frame_collector #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] frame_out [SAMPLES],
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [15:0]      frame_count
);

  localparam int              LOG2     = $clog2(SAMPLES);
  localparam logic [LOG2-1:0] LAST_IDX = LOG2'(SAMPLES - 1);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  bank_state_e      bank_state_q [2];
  bank_state_e      bank_state_d [2];
  logic [WIDTH-1:0] bank_q       [2][SAMPLES];
  logic [WIDTH-1:0] bank_d       [2][SAMPLES];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2-1:0]  wr_cnt_q, wr_cnt_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             accept;
  logic             release_frame;
  logic             last_sample;

  function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] v);
    logic [LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2; i++) begin
      r[i] = v[LOG2-1-i];
    end
    return r;
  endfunction

  // Outputs come straight from registers; in_ready never looks at in_valid.
  assign in_ready    = (bank_state_q[wr_bank_q] == BANK_EMPTY);
  assign frame_valid = (bank_state_q[rd_bank_q] == BANK_FULL);
  assign frame_out   = bank_q[rd_bank_q];
  assign frame_count = frame_count_q;

  always_comb begin
    accept        = in_valid && in_ready && !flush;
    release_frame = frame_valid && frame_ready;
    last_sample   = (wr_cnt_q == LAST_IDX);

    bank_d        = bank_q;
    bank_state_d  = bank_state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_cnt_d      = wr_cnt_q;
    frame_count_d = frame_count_q;

    if (accept) begin
      bank_d[wr_bank_q][bitrev(wr_cnt_q)] = in_sample;
    end

    // Read and write banks always differ when both events coincide.
    if (release_frame) begin
      bank_state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d               = ~rd_bank_q;
      frame_count_d           = frame_count_q + 16'd1;
    end

    if (flush) begin
      wr_cnt_d = '0;
    end else if (accept) begin
      if (last_sample) begin
        bank_state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d               = ~wr_bank_q;
        wr_cnt_d                = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        bank_state_q[b] <= BANK_EMPTY;
        for (int i = 0; i < SAMPLES; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      frame_count_q <= 16'd0;
    end else begin
      bank_state_q  <= bank_state_d;
      bank_q        <= bank_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_collector.sv
`default_nettype none
// ============================================================================
// tb_fft_frame_collector : vector table, directed corner sequences, random run
// Revision 1.0
// ============================================================================
module tb_fft_frame_collector;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_sample = '0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         frame_ready = 1'b0;
  logic         in_ready;
  logic         frame_valid;
  logic [W-1:0] frame_out [N];
  logic [15:0]  frame_count;

  int checks = 0;
  int errors = 0;

  // Reference: a FIFO of completed frames (at most two held) plus one partial frame.
  logic [15:0]  m_q [$];
  logic [W-1:0] m_part [N];
  int           m_wr = 0;
  logic [15:0]  m_cnt = 16'd0;

  logic [15:0]  got [$];
  int           stalls = 0;

  typedef struct {
    logic        v;
    logic [3:0]  s;
    logic        fl;
    logic        fr;
    logic        e_rdy;
    logic        e_fv;
    logic [15:0] e_cnt;
    logic [15:0] e_frame;
  } vec_t;

  vec_t tbl [15];

  fft_frame_collector #(.SAMPLES(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0] pack_dut();
    return {frame_out[3], frame_out[2], frame_out[1], frame_out[0]};
  endfunction

  function automatic int br(input int i);
    int r = 0;
    for (int k = 0; k < $clog2(N); k++) r = r * 2 + ((i >> k) & 1);
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic [3:0] s, input logic fl,
                              input logic fr, input logic rdy, input logic fv,
                              input logic [15:0] cnt, input logic [15:0] frm);
    vec_t t;
    t.v = v; t.s = s; t.fl = fl; t.fr = fr;
    t.e_rdy = rdy; t.e_fv = fv; t.e_cnt = cnt; t.e_frame = frm;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [3:0] s, input logic fl, input logic fr);
    logic acc;
    acc = v && (m_q.size() < 2) && !fl;
    if (m_q.size() > 0 && fr) begin
      void'(m_q.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (fl) begin
      m_wr = 0;
    end else if (acc) begin
      m_part[br(m_wr)] = s;
      m_wr++;
      if (m_wr == N) begin
        m_q.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
        m_wr = 0;
      end
    end
  endtask

  // Drive one clock of stimulus, compare against the reference, then advance it.
  task automatic cycle(input logic v, input logic [3:0] s, input logic fl, input logic fr,
                       output logic acc);
    in_valid = v; in_sample = s; flush = fl; frame_ready = fr;
    @(negedge clk);
    chk("in_ready", in_ready, m_q.size() < 2);
    chk("frame_valid", frame_valid, m_q.size() > 0);
    chk("frame_count", frame_count, m_cnt);
    if (m_q.size() > 0) chk("frame_out", pack_dut(), m_q[0]);
    if (frame_valid && fr) got.push_back(pack_dut());
    if (!in_ready) stalls++;
    acc = v && (m_q.size() < 2) && !fl;
    @(posedge clk);
    model_step(v, s, fl, fr);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_frame_out", pack_dut(), 16'h0000);
    m_q.delete();
    m_wr = 0;
    m_cnt = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;

    tbl[0]  = mk(1, 6,  0, 1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 2,  0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0,  0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 7,  0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0,  0, 1, 1, 1, 0, pk(6, 0, 2, 7));
    tbl[5]  = mk(0, 0,  0, 1, 1, 0, 1, 0);
    tbl[6]  = mk(1, 3,  0, 1, 1, 0, 1, 0);
    tbl[7]  = mk(1, 5,  0, 1, 1, 0, 1, 0);
    tbl[8]  = mk(1, 15, 1, 1, 1, 0, 1, 0);
    tbl[9]  = mk(1, 9,  0, 1, 1, 0, 1, 0);
    tbl[10] = mk(1, 1,  0, 1, 1, 0, 1, 0);
    tbl[11] = mk(1, 4,  0, 1, 1, 0, 1, 0);
    tbl[12] = mk(1, 2,  0, 1, 1, 0, 1, 0);
    tbl[13] = mk(0, 0,  0, 1, 1, 1, 1, pk(9, 4, 1, 2));
    tbl[14] = mk(0, 0,  0, 1, 1, 0, 2, 0);

    // Outputs while reset is held
    #2;
    chk("reset_frame_valid", frame_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_frame_out", pack_dut(), 16'h0000);
    chk("reset_frame_count", frame_count, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming, latency, and flush-with-dropped-sample vectors
    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].v; in_sample = tbl[i].s; flush = tbl[i].fl; frame_ready = tbl[i].fr;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_frame_valid", i), frame_valid, tbl[i].e_fv);
      chk($sformatf("vec%0d_frame_count", i), frame_count, tbl[i].e_cnt);
      if (tbl[i].e_fv) chk($sformatf("vec%0d_frame_out", i), pack_dut(), tbl[i].e_frame);
      @(posedge clk);
      #1;
    end

    // Back-pressure: both banks fill, input stalls, resumes after release
    do_reset();
    got.delete();
    stalls = 0;
    idx = 1;
    for (int k = 0; k < 60 && idx <= 12; k++) begin
      cycle(1'b1, 4'(idx), 1'b0, (k >= 14), acc);
      if (acc) idx++;
      if (k == 12) chk("t2_stall_frame", pack_dut(), pk(1, 3, 2, 4));
    end
    chk("t2_all_accepted", idx, 13);
    chk("t2_stall_cycles", stalls, 7);
    repeat (4) cycle(1'b0, 4'd0, 1'b0, 1'b1, acc);
    chk("t2_frames", got.size(), 3);
    if (got.size() == 3) begin
      chk("t2_frame0", got[0], pk(1, 3, 2, 4));
      chk("t2_frame1", got[1], pk(5, 7, 6, 8));
      chk("t2_frame2", got[2], pk(9, 11, 10, 12));
    end
    chk("t2_count", frame_count, 16'd3);

    // Last sample of one bank lands in the cycle the other bank is released
    do_reset();
    got.delete();
    for (int k = 1; k <= 7; k++) cycle(1'b1, 4'(k), 1'b0, 1'b0, acc);
    cycle(1'b1, 4'd8, 1'b0, 1'b1, acc);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, acc);
    chk("t6_released", got.size(), 1);
    if (got.size() == 1) chk("t6_first_frame", got[0], pk(1, 3, 2, 4));
    chk("t6_second_valid", frame_valid, 1'b1);
    chk("t6_second_frame", pack_dut(), pk(5, 7, 6, 8));

    // Asynchronous reset with a full bank and a half-full write bank
    do_reset();
    for (int k = 1; k <= 6; k++) cycle(1'b1, 4'(k), 1'b0, 1'b0, acc);
    chk("t5_pre_valid", frame_valid, 1'b1);
    do_reset();
    for (int k = 10; k <= 13; k++) cycle(1'b1, 4'(k), 1'b0, 1'b0, acc);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, acc);
    chk("t5_clean_frame", pack_dut(), pk(10, 12, 11, 13));

    // Full throughput with the consumer always ready
    do_reset();
    stalls = 0;
    for (int k = 0; k < 64; k++) cycle(1'b1, 4'($urandom), 1'b0, 1'b1, acc);
    repeat (2) cycle(1'b0, 4'd0, 1'b0, 1'b1, acc);
    chk("t4_no_stall", stalls, 0);
    chk("t4_count", frame_count, 16'd16);

    // Randomized traffic against the reference
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 20) == 0, $urandom % 2, acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
